// File: rtl/usart_tx_shifter.sv
// rtl/usart_tx_shifter.sv - USART transmit shift stage: FIFO pop, async frame serialiser, TXC event
module usart_tx_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic             tx_tick,
    input  logic             txen,
    input  logic [1:0]       chr_size,
    input  logic [1:0]       upm,
    input  logic             usbs,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_re,
    output logic             txd,
    output logic             txd_oe,
    output logic             busy,
    output logic             txc_set
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        parity_q, parity_d;
    logic        txd_q, txd_d;
    logic [1:0]  chr_size_q, chr_size_d;
    logic        par_en_q, par_en_d;
    logic        usbs_q, usbs_d;

    logic [7:0]  data_mask;
    logic        last_stop;
    logic        load;

    generate
        if (WIDTH > 8) begin : g_wide
            logic unused_hi;
            assign unused_hi = ^fifo_dout[WIDTH-1:8];
        end
    endgenerate

    always_comb begin
        case (chr_size)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase

        last_stop = tx_tick & (((state_q == S_STOP1) & ~usbs_q) | (state_q == S_STOP2));
        load      = tx_tick & txen & ~fifo_empty & ((state_q == S_IDLE) | last_stop);

        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        parity_d   = parity_q;
        txd_d      = txd_q;
        chr_size_d = chr_size_q;
        par_en_d   = par_en_q;
        usbs_d     = usbs_q;

        if (load) begin
            // Frame format is frozen here so mid-frame register writes cannot corrupt it
            shreg_d    = fifo_dout[7:0];
            parity_d   = (^(fifo_dout[7:0] & data_mask)) ^ upm[0];
            chr_size_d = chr_size;
            par_en_d   = upm[1];
            usbs_d     = usbs;
            bitcnt_d   = 3'd0;
            txd_d      = 1'b0;
            state_d    = S_START;
        end else if (tx_tick) begin
            case (state_q)
                S_START: begin
                    txd_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (bitcnt_q == ({1'b0, chr_size_q} + 3'd4)) begin
                        if (par_en_q) begin
                            txd_d   = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = S_STOP1;
                        end
                    end else begin
                        txd_d    = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    txd_d   = 1'b1;
                    state_d = S_STOP1;
                end
                S_STOP1: begin
                    txd_d   = 1'b1;
                    state_d = usbs_q ? S_STOP2 : S_IDLE;
                end
                S_STOP2: begin
                    txd_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q    <= S_IDLE;
            shreg_q    <= 8'h00;
            bitcnt_q   <= 3'd0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
            chr_size_q <= 2'b11;
            par_en_q   <= 1'b0;
            usbs_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
            chr_size_q <= chr_size_d;
            par_en_q   <= par_en_d;
            usbs_q     <= usbs_d;
        end
    end

    // A reload on the final stop tick suppresses TXC; fifo_empty already implies no reload
    assign fifo_re = load;
    assign txc_set = last_stop & fifo_empty;
    assign txd     = txd_q;
    assign busy    = (state_q != S_IDLE);
    assign txd_oe  = txen | busy;

endmodule

// File: tb/tb_usart_tx_shifter.sv
// tb/tb_usart_tx_shifter.sv - directed self-checking bench for usart_tx_shifter
module tb_usart_tx_shifter;

    logic       cp2 = 1'b0;
    logic       ireset = 1'b0;
    logic       tx_tick = 1'b0;
    logic       txen = 1'b0;
    logic [1:0] chr_size = 2'b11;
    logic [1:0] upm = 2'b00;
    logic       usbs = 1'b0;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_re, txd, txd_oe, busy, txc_set;

    logic [7:0] fifo_mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         re_cnt = 0;
    int         txc_cnt = 0;
    int         viol = 0;
    logic       re_s, txc_s;

    always #5 cp2 = ~cp2;

    usart_tx_shifter #(.WIDTH(8)) dut (
        .cp2(cp2), .ireset(ireset), .tx_tick(tx_tick), .txen(txen),
        .chr_size(chr_size), .upm(upm), .usbs(usbs),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
        .txd(txd), .txd_oe(txd_oe), .busy(busy), .txc_set(txc_set)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = fifo_mem[rd_ptr[3:0]];

    always @(posedge cp2) begin
        if (fifo_re && !fifo_empty) rd_ptr <= rd_ptr + 1;
    end

    always @(negedge cp2) begin
        if (fifo_re && (fifo_empty || !txen)) viol <= viol + 1;
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // One bit period of 16 cycles; strobes seen during the tick cycle are captured
    task automatic tick();
        @(negedge cp2);
        tx_tick = 1'b1;
        #1;
        re_s  = fifo_re;
        txc_s = txc_set;
        if (re_s) re_cnt = re_cnt + 1;
        if (txc_s) txc_cnt = txc_cnt + 1;
        @(negedge cp2);
        tx_tick = 1'b0;
        repeat (14) @(negedge cp2);
    endtask

    task automatic test_reset();
        ireset = 1'b0;
        repeat (3) @(negedge cp2);
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || txd_oe !== 1'b0 || fifo_re !== 1'b0 || txc_set !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: txd=%b busy=%b oe=%b re=%b txc=%b, required 1 0 0 0 0",
                     txd, busy, txd_oe, fifo_re, txc_set);
        end
        ireset = 1'b1;
        @(negedge cp2);
        tick();
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || re_s !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_tick: txd=%b busy=%b re=%b, required 1 0 0", txd, busy, re_s);
        end
    endtask

    task automatic test_8n1();
        logic [0:9] e;
        e = 10'b0101001011;
        chr_size = 2'b11; upm = 2'b00; usbs = 1'b0; txen = 1'b1;
        re_cnt = 0; txc_cnt = 0;
        push(8'hA5);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (txd !== e[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL 8n1_bit%0d: txd=%b busy=%b, required %b 1", i, txd, busy, e[i]);
            end
        end
        tick();
        n_checks++;
        if (txc_s !== 1'b1 || busy !== 1'b0 || txd !== 1'b1 || re_cnt != 1 || txc_cnt != 1) begin
            n_fail++;
            $display("FAIL 8n1_end: txc=%b busy=%b txd=%b re_cnt=%0d txc_cnt=%0d, required 1 0 1 1 1",
                     txc_s, busy, txd, re_cnt, txc_cnt);
        end
    endtask

    task automatic test_7e2();
        logic [0:10] e;
        e = 11'b01100101011;
        chr_size = 2'b10; upm = 2'b10; usbs = 1'b1;
        txc_cnt = 0;
        push(8'h53);
        for (int i = 0; i < 11; i++) begin
            tick();
            if (i == 2) begin
                chr_size = 2'b11; upm = 2'b00; usbs = 1'b0;
            end
            n_checks++;
            if (txd !== e[i] || txc_s !== 1'b0) begin
                n_fail++;
                $display("FAIL 7e2_bit%0d: txd=%b txc=%b, required %b 0", i, txd, txc_s, e[i]);
            end
        end
        tick();
        n_checks++;
        if (txc_s !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL 7e2_end: txc=%b busy=%b, required 1 0", txc_s, busy);
        end
    endtask

    task automatic test_5o1();
        logic [0:7] e;
        e = 8'b01111101;
        chr_size = 2'b00; upm = 2'b11; usbs = 1'b0;
        push(8'hFF);
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (txd !== e[i]) begin
                n_fail++;
                $display("FAIL 5o1_bit%0d: txd=%b, required %b", i, txd, e[i]);
            end
        end
        tick();
        n_checks++;
        if (txc_s !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL 5o1_end: txc=%b busy=%b, required 1 0", txc_s, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:29] e;
        e = 30'b0100000001_0000000011_0001111001;
        chr_size = 2'b11; upm = 2'b00; usbs = 1'b0;
        re_cnt = 0; txc_cnt = 0;
        push(8'h01); push(8'h80); push(8'h3C);
        for (int i = 0; i < 30; i++) begin
            tick();
            n_checks++;
            if (txd !== e[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: txd=%b busy=%b, required %b 1", i, txd, busy, e[i]);
            end
        end
        n_checks++;
        if (re_cnt != 3 || txc_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_counts: re=%0d txc=%0d, required 3 0", re_cnt, txc_cnt);
        end
        tick();
        n_checks++;
        if (txc_s !== 1'b1 || txc_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: txc=%b txc_cnt=%0d busy=%b, required 1 1 0", txc_s, txc_cnt, busy);
        end
    endtask

    task automatic test_txen_off();
        logic [0:9] e1;
        logic [0:9] e2;
        e1 = 10'b0101010101;
        e2 = 10'b0010101011;
        re_cnt = 0; txc_cnt = 0;
        push(8'h55); push(8'hAA);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) txen = 1'b0;
            n_checks++;
            if (txd !== e1[i]) begin
                n_fail++;
                $display("FAIL txen_f1_bit%0d: txd=%b, required %b", i, txd, e1[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || re_s !== 1'b0 || txc_s !== 1'b0 || txd_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL txen_hold%0d: txd=%b busy=%b re=%b txc=%b oe=%b, required 1 0 0 0 0",
                         i, txd, busy, re_s, txc_s, txd_oe);
            end
        end
        txen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (txd !== e2[i]) begin
                n_fail++;
                $display("FAIL txen_f2_bit%0d: txd=%b, required %b", i, txd, e2[i]);
            end
        end
        tick();
        n_checks++;
        if (re_cnt != 2 || txc_cnt != 1) begin
            n_fail++;
            $display("FAIL txen_counts: re=%0d txc=%0d, required 2 1", re_cnt, txc_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        logic [0:9] e;
        e = 10'b0111100001;
        push(8'hF0);
        tick(); tick(); tick();
        n_checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: txd=%b busy=%b, required 0 1", txd, busy);
        end
        @(posedge cp2);
        #2;
        ireset = 1'b0;
        txen = 1'b0;
        #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || txd_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: txd=%b busy=%b oe=%b, required 1 0 0", txd, busy, txd_oe);
        end
        repeat (2) @(negedge cp2);
        ireset = 1'b1;
        txen = 1'b1;
        txc_cnt = 0;
        push(8'h0F);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (txd !== e[i]) begin
                n_fail++;
                $display("FAIL rst_frame_bit%0d: txd=%b, required %b", i, txd, e[i]);
            end
        end
        tick();
        n_checks++;
        if (txc_s !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_frame_end: txc=%b busy=%b, required 1 0", txc_s, busy);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_5o1();
        test_back_to_back();
        test_txen_off();
        test_reset_midframe();
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL fifo_re_guard: %0d illegal pops, required 0", viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound, required completion");
        $fatal(1, "timeout");
    end

endmodule
